// File: rtl/ecc_pkg.sv
// Shared defaults and helpers for the ECC decode arbiter and its tag FIFO.
package ecc_pkg;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 16;
    localparam int ENC_WIDTH  = 21;

    // Width of a requester index; stays at least one bit for a single requester.
    function automatic int tag_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TAG_WIDTH = tag_bits(NUM_REQ);
    typedef logic [TAG_WIDTH-1:0] tag_t;

endpackage

// File: rtl/ecc_tag_fifo.sv
// In-flight tag FIFO: records which requester owns each codeword inside the decoder.
module ecc_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: storage is not reset; occupancy is tracked only by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ecc_decode_arbiter.sv
// Round-robin share of one ECC decode pipeline between NUM_REQ requesters,
// routing each decoded word back to its owner through an in-flight tag FIFO.
module ecc_decode_arbiter #(
    parameter int NUM_REQ    = ecc_pkg::NUM_REQ,
    parameter int DATA_WIDTH = ecc_pkg::DATA_WIDTH,
    parameter int ENC_WIDTH  = ecc_pkg::ENC_WIDTH,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ENC_WIDTH-1:0]    req_encoded,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]   rsp_decoded,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic                            dec_valid_in,
    output logic [ENC_WIDTH-1:0]            dec_encoded,
    input  logic                            dec_valid_out,
    input  logic [DATA_WIDTH-1:0]           dec_decoded,
    output logic                            err_underflow
);

    localparam int TW = ecc_pkg::tag_bits(NUM_REQ);
    localparam int CW = $clog2(TAG_DEPTH + 1);

    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] eligible;
    logic [TW-1:0]      last_grant;
    logic [TW-1:0]      grant_idx;
    logic [TW-1:0]      cand;
    logic [TW-1:0]      pop_tag;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               found;
    logic               xfer;
    logic               pop;
    int                 idx;

    assign eligible = req_valid & ~pend;
    assign xfer     = |(req_valid & req_ready);
    assign pop      = dec_valid_out && !fifo_empty;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        idx       = 0;
        req_ready = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = TW'(idx);
            if (!found && eligible[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        // Tag space is judged on the pre-pop count, so a full FIFO blocks even on a pop cycle.
        if (rstb && found && (fifo_count < CW'(TAG_DEPTH))) req_ready[grant_idx] = 1'b1;
    end

    ecc_tag_fifo #(
        .WIDTH (TW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rstb      (rstb),
        .push      (xfer),
        .push_data (grant_idx),
        .pop       (pop),
        .pop_data  (pop_tag),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pend          <= '0;
            last_grant    <= TW'(NUM_REQ - 1);
            dec_valid_in  <= 1'b0;
            dec_encoded   <= '0;
            rsp_valid     <= '0;
            rsp_decoded   <= '0;
            err_underflow <= 1'b0;
        end else begin
            dec_valid_in <= xfer;
            if (xfer) begin
                last_grant  <= grant_idx;
                dec_encoded <= req_encoded[grant_idx*ENC_WIDTH +: ENC_WIDTH];
            end
            if (dec_valid_out && fifo_empty) err_underflow <= 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                // pend stays set through the handshake cycle, so re-grant waits one cycle.
                if (xfer && (grant_idx == TW'(i))) pend[i] <= 1'b1;
                else if (rsp_valid[i] && rsp_ready[i]) pend[i] <= 1'b0;

                if (pop && (pop_tag == TW'(i))) begin
                    rsp_valid[i]                             <= 1'b1;
                    rsp_decoded[i*DATA_WIDTH +: DATA_WIDTH] <= dec_decoded;
                end else if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule
